// File: rtl/cnn_pkg.sv
// Shared CNN definitions: element width, layer dimensions seen by the conv, pool
// and control stages, pooling FSM encoding and an address-width helper.
package cnn_pkg;

  localparam int CNN_DATA_W = 8;

  localparam int CNN_CONV0_OUT_H  = 24;
  localparam int CNN_CONV0_OUT_W  = 24;
  localparam int CNN_CONV0_OUT_CH = 4;
  localparam int CNN_POOL0_OUT_H  = CNN_CONV0_OUT_H / 2;
  localparam int CNN_POOL0_OUT_W  = CNN_CONV0_OUT_W / 2;
  localparam int CNN_CONV1_OUT_H  = 8;
  localparam int CNN_CONV1_OUT_W  = 8;
  localparam int CNN_CONV1_OUT_CH = 8;
  localparam int CNN_POOL1_OUT_H  = CNN_CONV1_OUT_H / 2;
  localparam int CNN_POOL1_OUT_W  = CNN_CONV1_OUT_W / 2;

  typedef enum logic [2:0] {
    POOL_IDLE,
    POOL_READ,
    POOL_LAST,
    POOL_WRITE,
    POOL_DONE,
    POOL_WAIT_LOW
  } pool_state_t;

  // Never returns 0 so that tiny maps still get a one-bit address bus.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cnn_pool_2x2_if.sv
// Buffer/control bundle of the pooling stage; master is the pool, slave is the
// control unit plus the input and output buffers.
interface cnn_pool_2x2_if #(
  parameter int DATA_W    = 8,
  parameter int RD_ADDR_W = 12,
  parameter int WR_ADDR_W = 10
) ();

  // No back-pressure: RdEn/RdAddr are a request the input buffer always accepts,
  // returning RdData one cycle later; WrEn/WrAddr/WrData commit in the cycle
  // they are high; Enable is a level and Done a single-cycle pulse.
  logic                 CNN_Pool_Enable_InHigh;
  logic [DATA_W-1:0]    CNN_Pool_RdData_InData;
  logic                 CNN_Pool_RdEn_Out_Data;
  logic [RD_ADDR_W-1:0] CNN_Pool_RdAddr_Out_Data;
  logic                 CNN_Pool_WrEn_Out_Data;
  logic [WR_ADDR_W-1:0] CNN_Pool_WrAddr_Out_Data;
  logic [DATA_W-1:0]    CNN_Pool_WrData_Out_Data;
  logic                 CNN_Pool_Done_Out_Data;

  modport master (
    input  CNN_Pool_Enable_InHigh,
    input  CNN_Pool_RdData_InData,
    output CNN_Pool_RdEn_Out_Data,
    output CNN_Pool_RdAddr_Out_Data,
    output CNN_Pool_WrEn_Out_Data,
    output CNN_Pool_WrAddr_Out_Data,
    output CNN_Pool_WrData_Out_Data,
    output CNN_Pool_Done_Out_Data
  );

  modport slave (
    output CNN_Pool_Enable_InHigh,
    output CNN_Pool_RdData_InData,
    input  CNN_Pool_RdEn_Out_Data,
    input  CNN_Pool_RdAddr_Out_Data,
    input  CNN_Pool_WrEn_Out_Data,
    input  CNN_Pool_WrAddr_Out_Data,
    input  CNN_Pool_WrData_Out_Data,
    input  CNN_Pool_Done_Out_Data
  );

endinterface

// File: rtl/cnn_pool_addr_gen.sv
// Window/output counters for 2x2 stride-2 pooling; addresses are built from
// running offsets only.
module cnn_pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int IN_H      = 24,
  parameter int IN_W      = 24,
  parameter int CHANNELS  = 4,
  parameter int RD_ADDR_W = addr_w(CHANNELS*IN_H*IN_W),
  parameter int WR_ADDR_W = addr_w(CHANNELS*IN_H*IN_W/4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance_elem,
  input  logic                 advance_win,
  output logic [1:0]           elem_k,
  output logic [RD_ADDR_W-1:0] rd_addr,
  output logic [WR_ADDR_W-1:0] wr_addr,
  output logic                 last_win
);

  localparam int OUT_W = IN_W / 2;
  localparam int N_OUT = CHANNELS * IN_H * IN_W / 4;
  localparam int COL_W = addr_w(OUT_W);

  localparam logic [RD_ADDR_W-1:0] ROW_STEP  = RD_ADDR_W'(IN_W);
  localparam logic [RD_ADDR_W-1:0] COL_STEP  = RD_ADDR_W'(2);
  // Row end and channel end both land IN_W+2 past the current top-left corner,
  // because channels are stored back to back.
  localparam logic [RD_ADDR_W-1:0] WRAP_STEP = RD_ADDR_W'(IN_W + 2);
  localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(OUT_W - 1);
  localparam logic [WR_ADDR_W-1:0] LAST_OUT  = WR_ADDR_W'(N_OUT - 1);

  logic [1:0]           k_q;
  logic [COL_W-1:0]     ocol_q;
  logic [RD_ADDR_W-1:0] win_base_q;
  logic [WR_ADDR_W-1:0] wr_addr_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      k_q        <= '0;
      ocol_q     <= '0;
      win_base_q <= '0;
      wr_addr_q  <= '0;
    end else begin
      if (advance_elem) k_q <= k_q + 2'd1;
      if (advance_win) begin
        wr_addr_q <= wr_addr_q + WR_ADDR_W'(1);
        if (ocol_q == LAST_COL) begin
          ocol_q     <= '0;
          win_base_q <= win_base_q + WRAP_STEP;
        end else begin
          ocol_q     <= ocol_q + COL_W'(1);
          win_base_q <= win_base_q + COL_STEP;
        end
      end
    end
  end

  assign elem_k   = k_q;
  assign rd_addr  = win_base_q + (k_q[1] ? ROW_STEP : '0) + {{(RD_ADDR_W-1){1'b0}}, k_q[0]};
  assign wr_addr  = wr_addr_q;
  assign last_win = (wr_addr_q == LAST_OUT);

endmodule

// File: rtl/cnn_pool_2x2.sv
// 2x2 stride-2 signed max-pooling stage: reads windows from the conv output
// buffer, writes one max per window, pulses Done once per enable.
module cnn_pool_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W    = CNN_DATA_W,
  parameter int IN_H      = CNN_CONV0_OUT_H,
  parameter int IN_W      = CNN_CONV0_OUT_W,
  parameter int CHANNELS  = CNN_CONV0_OUT_CH,
  parameter int RD_ADDR_W = addr_w(CHANNELS*IN_H*IN_W),
  parameter int WR_ADDR_W = addr_w(CHANNELS*IN_H*IN_W/4)
) (
  input  logic           CNN_Pool_CLOCK_50,
  input  logic           CNN_Pool_RESET_InHigh,
  cnn_pool_2x2_if.master bus,
  output pool_state_t    CNN_Pool_State_Out_Data
);

  pool_state_t state_q, state_d;

  logic                     clear, adv_elem, adv_win;
  logic [1:0]               elem_k;
  logic [RD_ADDR_W-1:0]     rd_addr;
  logic [WR_ADDR_W-1:0]     wr_addr;
  logic                     last_win;
  logic                     enable;
  logic signed [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] max_q;

  assign enable  = bus.CNN_Pool_Enable_InHigh;
  assign rd_data = $signed(bus.CNN_Pool_RdData_InData);

  cnn_pool_addr_gen #(
    .IN_H      (IN_H),
    .IN_W      (IN_W),
    .CHANNELS  (CHANNELS),
    .RD_ADDR_W (RD_ADDR_W),
    .WR_ADDR_W (WR_ADDR_W)
  ) u_addr_gen (
    .clk          (CNN_Pool_CLOCK_50),
    .rst          (CNN_Pool_RESET_InHigh),
    .clear        (clear),
    .advance_elem (adv_elem),
    .advance_win  (adv_win),
    .elem_k       (elem_k),
    .rd_addr      (rd_addr),
    .wr_addr      (wr_addr),
    .last_win     (last_win)
  );

  always_ff @(posedge CNN_Pool_CLOCK_50) begin
    if (CNN_Pool_RESET_InHigh) state_q <= POOL_IDLE;
    else                       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    adv_elem = 1'b0;
    adv_win  = 1'b0;
    case (state_q)
      POOL_IDLE: begin
        clear = 1'b1;
        if (enable) state_d = POOL_READ;
      end
      POOL_READ: begin
        if (!enable) state_d = POOL_IDLE;
        else begin
          adv_elem = 1'b1;
          if (elem_k == 2'd3) state_d = POOL_LAST;
        end
      end
      POOL_LAST: state_d = enable ? POOL_WRITE : POOL_IDLE;
      POOL_WRITE: begin
        if (!enable) state_d = POOL_IDLE;
        else begin
          adv_win = 1'b1;
          state_d = last_win ? POOL_DONE : POOL_READ;
        end
      end
      POOL_DONE:     state_d = POOL_WAIT_LOW;
      POOL_WAIT_LOW: if (!enable) state_d = POOL_IDLE;
      default:       state_d = POOL_IDLE;
    endcase
  end

  // Data lags the address by one cycle: READ with k=1 sees element 0, and the
  // LAST cycle sees element 3. Strict '>' keeps the earlier element on a tie.
  always_ff @(posedge CNN_Pool_CLOCK_50) begin
    if (CNN_Pool_RESET_InHigh) begin
      max_q <= '0;
    end else if (state_q == POOL_READ && elem_k == 2'd1) begin
      max_q <= rd_data;
    end else if (((state_q == POOL_READ && elem_k[1]) || state_q == POOL_LAST) &&
                 (rd_data > max_q)) begin
      max_q <= rd_data;
    end
  end

  assign bus.CNN_Pool_RdEn_Out_Data   = (state_q == POOL_READ);
  assign bus.CNN_Pool_RdAddr_Out_Data = (state_q == POOL_READ) ? rd_addr : '0;
  assign bus.CNN_Pool_WrEn_Out_Data   = (state_q == POOL_WRITE);
  assign bus.CNN_Pool_WrAddr_Out_Data = (state_q == POOL_WRITE) ? wr_addr : '0;
  assign bus.CNN_Pool_WrData_Out_Data = (state_q == POOL_WRITE) ? max_q : '0;
  assign bus.CNN_Pool_Done_Out_Data   = (state_q == POOL_DONE);
  assign CNN_Pool_State_Out_Data      = state_q;

endmodule

// File: tb/tb_cnn_pool_2x2.sv
// Bench for cnn_pool_2x2 on a two-channel 4x4 map: cycle-exact model of the
// read/write/done schedule derived from window index arithmetic.
module tb_cnn_pool_2x2;
  import cnn_pkg::*;

  localparam int DATA_W    = 8;
  localparam int IN_H      = 4;
  localparam int IN_W      = 4;
  localparam int CHANNELS  = 2;
  localparam int RD_ADDR_W = 5;
  localparam int WR_ADDR_W = 3;
  localparam int MEM_D     = CHANNELS * IN_H * IN_W;
  localparam int OH        = IN_H / 2;
  localparam int OW        = IN_W / 2;
  localparam int N         = CHANNELS * OH * OW;
  localparam int NEVER     = 1 << 30;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  pool_state_t dut_state;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_pool_2x2_if #(.DATA_W(DATA_W), .RD_ADDR_W(RD_ADDR_W), .WR_ADDR_W(WR_ADDR_W)) bus ();

  cnn_pool_2x2 #(
    .DATA_W(DATA_W), .IN_H(IN_H), .IN_W(IN_W), .CHANNELS(CHANNELS),
    .RD_ADDR_W(RD_ADDR_W), .WR_ADDR_W(WR_ADDR_W)
  ) dut (
    .CNN_Pool_CLOCK_50       (clk),
    .CNN_Pool_RESET_InHigh   (rst),
    .bus                     (bus),
    .CNN_Pool_State_Out_Data (dut_state)
  );

  // ---------------- input buffer (synchronous read) ----------------
  logic signed [DATA_W-1:0] mem [MEM_D];

  always @(posedge clk)
    if (bus.CNN_Pool_RdEn_Out_Data) bus.CNN_Pool_RdData_InData <= mem[bus.CNN_Pool_RdAddr_Out_Data];

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int e_cyc    = -1;
  int stop_cyc = NEVER;
  bit mon_on   = 1'b0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int elem_addr(input int n, input int k);
    int ch, rem, orow, ocol;
    ch   = n / (OH * OW);
    rem  = n % (OH * OW);
    orow = rem / OW;
    ocol = rem % OW;
    return ch * IN_H * IN_W + (2 * orow + k / 2) * IN_W + 2 * ocol + k % 2;
  endfunction

  function automatic void build_model();
    logic signed [DATA_W-1:0] m;
    exp_q.delete();
    for (int n = 0; n < N; n++) begin
      m = mem[elem_addr(n, 0)];
      for (int k = 1; k < 4; k++)
        if (mem[elem_addr(n, k)] > m) m = mem[elem_addr(n, k)];
      exp_q.push_back(m);
    end
  endfunction

  // Per-cycle compare: window n occupies cycles E+6n+1..E+6n+6 (reads in the
  // first four, write in the sixth); Done sits at E+6N+1.
  int  d, wn, ph;
  int  x_rd, x_rda, x_wr, x_wra, x_wrd, x_done;
  always @(negedge clk) if (mon_on) begin
    x_rd = 0; x_rda = 0; x_wr = 0; x_wra = 0; x_wrd = 0; x_done = 0;
    if (e_cyc >= 0 && cyc < stop_cyc) begin
      d = cyc - e_cyc;
      if (d >= 1) begin
        wn = (d - 1) / 6;
        ph = (d - 1) % 6;
        if (wn < N) begin
          if (ph < 4) begin
            x_rd = 1; x_rda = elem_addr(wn, ph);
          end else if (ph == 5) begin
            x_wr = 1; x_wra = wn; x_wrd = int'(exp_q[wn]);
          end
        end else if (d == 6 * N + 1) begin
          x_done = 1;
        end
      end
    end
    chk("rd_en",   int'(bus.CNN_Pool_RdEn_Out_Data),   x_rd);
    chk("rd_addr", int'(bus.CNN_Pool_RdAddr_Out_Data), x_rda);
    chk("wr_en",   int'(bus.CNN_Pool_WrEn_Out_Data),   x_wr);
    chk("wr_addr", int'(bus.CNN_Pool_WrAddr_Out_Data), x_wra);
    chk("wr_data", int'(bus.CNN_Pool_WrData_Out_Data), x_wrd);
    chk("done",    int'(bus.CNN_Pool_Done_Out_Data),   x_done);
    if (bus.CNN_Pool_WrEn_Out_Data) wr_cnt++;
    if (bus.CNN_Pool_Done_Out_Data) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    tick();
    bus.CNN_Pool_Enable_InHigh = 1'b1;
    e_cyc    = cyc;
    stop_cyc = NEVER;
  endtask

  task automatic full_run(input string tag);
    int w0, d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    start_run();
    repeat (6 * N + 1) tick();
    repeat (10) tick();
    chk({tag, "_writes"}, wr_cnt - w0, N);
    chk({tag, "_dones"},  done_cnt - d0, 1);
    chk({tag, "_wait_low"}, int'(dut_state), int'(POOL_WAIT_LOW));
    bus.CNN_Pool_Enable_InHigh = 1'b0;
    repeat (2) tick();
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < MEM_D; i++) mem[i] = DATA_W'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < MEM_D; i++) mem[i] = DATA_W'($urandom_range(0, 255));
  endtask

  int basic_exp [8] = '{5, 7, 13, 15, 21, 23, 29, 31};

  initial begin
    int w0, d0;
    rst = 1'b1;
    bus.CNN_Pool_Enable_InHigh = 1'b0;
    fill_ramp();
    build_model();
    tick();
    tick();
    chk("reset_state", int'(dut_state), int'(POOL_IDLE));
    chk("reset_rd_en", int'(bus.CNN_Pool_RdEn_Out_Data), 0);
    chk("reset_wr_en", int'(bus.CNN_Pool_WrEn_Out_Data), 0);
    chk("reset_done",  int'(bus.CNN_Pool_Done_Out_Data), 0);
    chk("reset_wr_data", int'(bus.CNN_Pool_WrData_Out_Data), 0);
    rst = 1'b0;
    mon_on = 1'b1;
    tick();

    // Basic ramp map, then the same run again after Enable drops and re-rises.
    for (int i = 0; i < 8; i++) chk($sformatf("model_basic%0d", i), int'(exp_q[i]), basic_exp[i]);
    full_run("basic");
    full_run("rerun");

    // Signed compare windows at the start of channel 0.
    fill_random();
    mem[0] = -8'sd128; mem[1] = -8'sd1;  mem[4] = -8'sd5;   mem[5] = -8'sd2;
    mem[2] = 8'sd127;  mem[3] = 8'sd127; mem[6] = -8'sd128; mem[7] = 8'sd0;
    build_model();
    chk("model_signed0", int'($signed(exp_q[0])), -1);
    chk("model_signed1", int'($signed(exp_q[1])), 127);
    full_run("signed");

    // Abort: Enable sampled low at E+9.
    fill_random();
    build_model();
    w0 = wr_cnt;
    d0 = done_cnt;
    start_run();
    repeat (9) tick();
    bus.CNN_Pool_Enable_InHigh = 1'b0;
    stop_cyc = e_cyc + 10;
    tick();
    chk("abort_idle", int'(dut_state), int'(POOL_IDLE));
    repeat (10) tick();
    chk("abort_writes", wr_cnt - w0, 1);
    chk("abort_dones",  done_cnt - d0, 0);

    // Reset at E+3, then a clean basic run.
    fill_ramp();
    build_model();
    start_run();
    repeat (3) tick();
    rst = 1'b1;
    bus.CNN_Pool_Enable_InHigh = 1'b0;
    stop_cyc = e_cyc + 4;
    tick();
    chk("midrst_state", int'(dut_state), int'(POOL_IDLE));
    rst = 1'b0;
    repeat (2) tick();
    full_run("after_rst");

    // Random maps.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      build_model();
      full_run($sformatf("rand%0d", r));
    end

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_pool_2x2.md
# cnn_pool_2x2

Feature-map 2x2 max-pooling stage (stride 2) of the CNN pipeline, used for both pooling layers (Pool0, Pool1). It runs while the CNN control unit holds its pool enable high. It reads the preceding convolution's output buffer through a synchronous-read port and writes the pooled map to the next layer's buffer. It raises a one-cycle done pulse, which the control unit consumes to advance to the next layer.

## Interface
Parameters:
- DATA_W, 8: signed element width.
- IN_H, 24: input map height; must be even.
- IN_W, 24: input map width; must be even.
- CHANNELS, 4: number of maps, stored consecutively.
- RD_ADDR_W, clog2(CHANNELS*IN_H*IN_W): input address width (derived).
- WR_ADDR_W, clog2(CHANNELS*IN_H*IN_W/4): output address width (derived).

Ports:
- CNN_Pool_CLOCK_50  in  1  sole clock, rising edge.
- CNN_Pool_RESET_InHigh  in  1  synchronous, active-high reset.
- CNN_Pool_Enable_InHigh  in  1  level enable from the control unit.
- CNN_Pool_RdData_InData  in  DATA_W  input buffer data; valid the cycle after the address is issued.
- CNN_Pool_RdEn_Out_Data  out  1  input buffer read strobe.
- CNN_Pool_RdAddr_Out_Data  out  RD_ADDR_W  input buffer address.
- CNN_Pool_WrEn_Out_Data  out  1  output buffer write strobe.
- CNN_Pool_WrAddr_Out_Data  out  WR_ADDR_W  output buffer address.
- CNN_Pool_WrData_Out_Data  out  DATA_W  pooled value (signed max).
- CNN_Pool_Done_Out_Data  out  1  one-cycle completion pulse.

## Operation
- Input layout: addr = ch*IN_H*IN_W + r*IN_W + c.
- Output layout: addr = ch*(IN_H/2)*(IN_W/2) + orow*(IN_W/2) + ocol.
- Scan order: channel outermost, then orow, then ocol.
- Window read order k=0..3: (2orow,2ocol), (2orow,2ocol+1), (2orow+1,2ocol), (2orow+1,2ocol+1).
- Comparison is signed. On a tie, the earlier element is kept; the output value is the same either way.
- Addresses come from incrementing counters and offsets. No multipliers.
- States:
  - IDLE: wait for Enable. Counters are zeroed.
  - READ: 4 cycles. RdEn=1, RdAddr=element k. At the data return for k=0 the running max is loaded; for k=1..2 it is compared and updated.
  - LAST: 1 cycle. Folds in element k=3.
  - WRITE: 1 cycle. WrEn=1, WrAddr=current output index, WrData=max. Goes to READ for the next window, or to DONE after the final output.
  - DONE: 1 cycle. Done=1.
  - WAIT_LOW: hold until Enable=0, then go to IDLE. This stops a re-trigger while the control unit leaves the pool state.
- Enable dropping in READ, LAST or WRITE aborts: go to IDLE next cycle. No further writes, no Done. Counters reset.
- RdEn and WrEn are never high in the same cycle.

## Timing
- Reset: state IDLE, counters 0. Every output is 0 (RdEn, RdAddr, WrEn, WrAddr, WrData, Done).
- Let E be the cycle in which IDLE samples Enable=1.
- First window: READ occupies E+1..E+4. Data k is on RdData at E+2+k. LAST is E+5. WRITE is E+6.
- Every window takes 6 cycles. Output n (0-based) is written at E+6(n+1).
- With N = CHANNELS*IN_H*IN_W/4, Done is high at exactly E+6N+1.
- Default parameters: N=576, so Done at E+3457.
- Reset asserted mid-run wins over everything: next cycle is IDLE with all outputs 0.

## Structure
- Shared package cnn_pkg holds:
  - the state encoding (IDLE, READ, LAST, WRITE, DONE, WAIT_LOW);
  - CNN_DATA_W;
  - the layer dimension constants shared with the conv stages and control unit.
- Sub-module cnn_pool_addr_gen holds the counters and address arithmetic. It has advance/clear inputs and outputs RdAddr for window element k, WrAddr, and a last-window flag.
- Compare datapath and FSM stay in the top module.

## Test plan
- Basic 4x4 map: params IN_H=IN_W=4, CHANNELS=1, memory holds values 0..15 row-major. Enable -> writes 5,7,13,15 to addresses 0..3; Done exactly at E+25.
- Signed compare, 2x2 map: window {-128,-1,-5,-2} -> write -1. Then window {127,127,-128,0} -> write 127.
- Multi-channel layout: CHANNELS=2, 4x4, ch1 = ch0+16. Enable -> WrAddr 4..7 carry 21,23,29,31. No address beyond 7 is ever written.
- Handshake: hold Enable high for 10 cycles after Done -> no RdEn, WrEn or second Done. Drop Enable, re-raise it -> full run repeats with identical writes.
- Abort: drop Enable at E+9 -> exactly one write (at E+6), no Done, IDLE by E+10.
- Reset: assert Reset at E+3 -> all outputs 0 next cycle. Restart produces the basic-scenario result.
